// File: rtl/instr_fetch_unit_if.sv
// Bundle of PC-register, instruction-memory and decode signals seen by the fetch unit.
// The master modport is the fetch unit; the slave modport is its surroundings.
interface instr_fetch_unit_if #(
    parameter int WL    = 32,
    parameter int CNT_W = 16
);
    logic [WL-1:0]    PC_in;
    logic             MEM_ACK;
    logic [WL-1:0]    MEM_RDATA;
    logic             IR_READY;
    logic             FLUSH;
    logic             PC_EN;
    logic             MEM_REQ;
    logic [WL-1:0]    MEM_ADDR;
    logic [WL-1:0]    IR_out;
    logic             IR_VALID;
    logic             FAULT;
    logic [CNT_W-1:0] FETCH_CNT;

    modport master (
        input  PC_in, MEM_ACK, MEM_RDATA, IR_READY, FLUSH,
        output PC_EN, MEM_REQ, MEM_ADDR, IR_out, IR_VALID, FAULT, FETCH_CNT
    );

    modport slave (
        output PC_in, MEM_ACK, MEM_RDATA, IR_READY, FLUSH,
        input  PC_EN, MEM_REQ, MEM_ADDR, IR_out, IR_VALID, FAULT, FETCH_CNT
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: samples the PC, reads memory with req/ack, holds the word for
// decode and pulses the PC enable once the instruction is consumed or flushed.
module instr_fetch_unit #(
    parameter int WL      = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    instr_fetch_unit_if.master bus
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_UPDATE,
        S_ERR
    } state_t;

    state_t           state_q;
    logic             pc_en_q;
    logic             mem_req_q;
    logic             ir_valid_q;
    logic             fault_q;
    logic             drop_q;
    logic [WL-1:0]    mem_addr_q;
    logic [WL-1:0]    ir_q;
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] fetch_cnt_d;
    logic [TW-1:0]    tmo_q;
    logic [TW-1:0]    tmo_d;

    assign fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    assign tmo_d       = tmo_q + TW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            pc_en_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            ir_valid_q  <= 1'b0;
            fault_q     <= 1'b0;
            drop_q      <= 1'b0;
            mem_addr_q  <= '0;
            ir_q        <= '0;
            fetch_cnt_q <= '0;
            tmo_q       <= '0;
        end else begin
            pc_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.FLUSH) begin
                        pc_en_q <= 1'b1;
                        state_q <= S_UPDATE;
                    end else if (bus.PC_in[1:0] != 2'b00) begin
                        fault_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        mem_addr_q <= bus.PC_in;
                        mem_req_q  <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.MEM_ACK) begin
                        mem_req_q <= 1'b0;
                        // A flushed response is swallowed: IR is left untouched.
                        if (drop_q || bus.FLUSH) begin
                            drop_q  <= 1'b0;
                            pc_en_q <= 1'b1;
                            state_q <= S_UPDATE;
                        end else begin
                            ir_q       <= bus.MEM_RDATA;
                            ir_valid_q <= 1'b1;
                            state_q    <= S_HOLD;
                        end
                    end else begin
                        if (bus.FLUSH) drop_q <= 1'b1;
                        if (tmo_q == TW'(TIMEOUT - 1)) begin
                            mem_req_q <= 1'b0;
                            fault_q   <= 1'b1;
                            state_q   <= S_ERR;
                        end else begin
                            tmo_q <= tmo_d;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.FLUSH) begin
                        ir_valid_q <= 1'b0;
                        pc_en_q    <= 1'b1;
                        state_q    <= S_UPDATE;
                    end else if (bus.IR_READY) begin
                        ir_valid_q  <= 1'b0;
                        fetch_cnt_q <= fetch_cnt_d;
                        pc_en_q     <= 1'b1;
                        state_q     <= S_UPDATE;
                    end
                end
                S_UPDATE: state_q <= S_IDLE;
                S_ERR:    state_q <= S_ERR;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.PC_EN     = pc_en_q;
    assign bus.MEM_REQ   = mem_req_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.IR_out    = ir_q;
    assign bus.IR_VALID  = ir_valid_q;
    assign bus.FAULT     = fault_q;
    assign bus.FETCH_CNT = fetch_cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written
// sequences for timeout, async reset and late acknowledge.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.WL(32), .CNT_W(16)) bus ();

    instr_fetch_unit #(.WL(32), .TIMEOUT(4), .CNT_W(16)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        fl;
        logic        pcen;
        logic        req;
        logic [31:0] addr;
        logic [31:0] ir;
        logic        v;
        logic        f;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                       input logic rdy, input logic fl, input logic pcen, input logic req,
                       input logic [31:0] addr, input logic [31:0] ir, input logic v,
                       input logic f, input logic [15:0] cnt);
        vec_t t;
        t.pc = pc; t.ack = ack; t.rd = rd; t.rdy = rdy; t.fl = fl;
        t.pcen = pcen; t.req = req; t.addr = addr; t.ir = ir; t.v = v; t.f = f; t.cnt = cnt;
        vq.push_back(t);
    endtask

    task automatic drive(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                         input logic rdy, input logic fl);
        bus.PC_in     = pc;
        bus.MEM_ACK   = ack;
        bus.MEM_RDATA = rd;
        bus.IR_READY  = rdy;
        bus.FLUSH     = fl;
    endtask

    task automatic check(input string name, input logic pcen, input logic req,
                         input logic [31:0] addr, input logic [31:0] ir, input logic v,
                         input logic f, input logic [15:0] cnt);
        logic [83:0] act;
        logic [83:0] exp;
        act = {bus.PC_EN, bus.MEM_REQ, bus.MEM_ADDR, bus.IR_out, bus.IR_VALID, bus.FAULT, bus.FETCH_CNT};
        exp = {pcen, req, addr, ir, v, f, cnt};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got pcen=%b req=%b addr=%h ir=%h v=%b f=%b cnt=%0d want pcen=%b req=%b addr=%h ir=%h v=%b f=%b cnt=%0d",
                     name, bus.PC_EN, bus.MEM_REQ, bus.MEM_ADDR, bus.IR_out, bus.IR_VALID,
                     bus.FAULT, bus.FETCH_CNT, pcen, req, addr, ir, v, f, cnt);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.PC_EN && bus.MEM_REQ) begin
            bad++;
            $display("FAIL pcen_req_overlap: got PC_EN=1 MEM_REQ=1 want not both");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int reqcyc;

        // Zero-wait memory, decode always ready: 4 cycles per instruction.
        add(32'h0,  1, 32'h2008_0005, 1, 0,  0, 1, 32'h0, 32'h0,         0, 0, 0);
        add(32'h0,  1, 32'h2008_0005, 1, 0,  0, 0, 32'h0, 32'h2008_0005, 1, 0, 0);
        add(32'h0,  1, 32'h2008_0005, 1, 0,  1, 0, 32'h0, 32'h2008_0005, 0, 0, 1);
        add(32'h4,  1, 32'h2008_0005, 1, 0,  0, 0, 32'h0, 32'h2008_0005, 0, 0, 1);
        add(32'h4,  1, 32'h2008_0005, 1, 0,  0, 1, 32'h4, 32'h2008_0005, 0, 0, 1);
        add(32'h4,  1, 32'h2008_0005, 1, 0,  0, 0, 32'h4, 32'h2008_0005, 1, 0, 1);
        add(32'h4,  1, 32'h2008_0005, 1, 0,  1, 0, 32'h4, 32'h2008_0005, 0, 0, 2);
        add(32'h8,  0, 32'h0,         0, 0,  0, 0, 32'h4, 32'h2008_0005, 0, 0, 2);
        // Ack in the last WAIT cycle before timeout; decode stalls 5 cycles.
        add(32'h8,  0, 32'h0,         0, 0,  0, 1, 32'h8, 32'h2008_0005, 0, 0, 2);
        add(32'h8,  0, 32'h0,         0, 0,  0, 1, 32'h8, 32'h2008_0005, 0, 0, 2);
        add(32'hC,  0, 32'h0,         0, 0,  0, 1, 32'h8, 32'h2008_0005, 0, 0, 2);
        add(32'hC,  0, 32'h0,         0, 0,  0, 1, 32'h8, 32'h2008_0005, 0, 0, 2);
        add(32'hC,  1, 32'h1111_2222, 0, 0,  0, 0, 32'h8, 32'h1111_2222, 1, 0, 2);
        for (int i = 0; i < 5; i++)
            add(32'hC, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h8, 32'h1111_2222, 1, 0, 2);
        add(32'hC,  0, 32'h0,         1, 0,  1, 0, 32'h8, 32'h1111_2222, 0, 0, 3);
        add(32'h10, 0, 32'h0,         0, 0,  0, 0, 32'h8, 32'h1111_2222, 0, 0, 3);
        // Flush in the second WAIT cycle; the late response is dropped.
        add(32'h10, 0, 32'h0,         0, 0,  0, 1, 32'h10, 32'h1111_2222, 0, 0, 3);
        add(32'h10, 0, 32'h0,         0, 0,  0, 1, 32'h10, 32'h1111_2222, 0, 0, 3);
        add(32'h10, 0, 32'h0,         0, 1,  0, 1, 32'h10, 32'h1111_2222, 0, 0, 3);
        add(32'h10, 0, 32'h0,         0, 0,  0, 1, 32'h10, 32'h1111_2222, 0, 0, 3);
        add(32'h10, 1, 32'hDEAD_BEEF, 0, 0,  1, 0, 32'h10, 32'h1111_2222, 0, 0, 3);
        add(32'h14, 0, 32'h0,         0, 0,  0, 0, 32'h10, 32'h1111_2222, 0, 0, 3);
        // Flush beats IR_READY in HOLD.
        add(32'h14, 0, 32'h0,         0, 0,  0, 1, 32'h14, 32'h1111_2222, 0, 0, 3);
        add(32'h14, 1, 32'hA5A5_A5A5, 0, 0,  0, 0, 32'h14, 32'hA5A5_A5A5, 1, 0, 3);
        add(32'h14, 0, 32'h0,         1, 1,  1, 0, 32'h14, 32'hA5A5_A5A5, 0, 0, 3);
        add(32'h18, 0, 32'h0,         0, 0,  0, 0, 32'h14, 32'hA5A5_A5A5, 0, 0, 3);
        // Flush in IDLE, then flush coinciding with the ack.
        add(32'h18, 0, 32'h0,         0, 1,  1, 0, 32'h14, 32'hA5A5_A5A5, 0, 0, 3);
        add(32'h18, 0, 32'h0,         0, 0,  0, 0, 32'h14, 32'hA5A5_A5A5, 0, 0, 3);
        add(32'h18, 0, 32'h0,         0, 0,  0, 1, 32'h18, 32'hA5A5_A5A5, 0, 0, 3);
        add(32'h18, 1, 32'h5555_5555, 0, 1,  1, 0, 32'h18, 32'hA5A5_A5A5, 0, 0, 3);
        add(32'h6,  0, 32'h0,         0, 0,  0, 0, 32'h18, 32'hA5A5_A5A5, 0, 0, 3);
        // Misaligned PC: fault and freeze.
        add(32'h6,  0, 32'h0,         0, 0,  0, 0, 32'h18, 32'hA5A5_A5A5, 0, 1, 3);
        add(32'h0,  1, 32'h7777_7777, 1, 1,  0, 0, 32'h18, 32'hA5A5_A5A5, 0, 1, 3);
        add(32'h0,  1, 32'h7777_7777, 1, 0,  0, 0, 32'h18, 32'hA5A5_A5A5, 0, 1, 3);

        drive(32'h0, 0, 32'h0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 0, 32'h0, 32'h0, 0, 0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].pc, vq[i].ack, vq[i].rd, vq[i].rdy, vq[i].fl);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vq[i].pcen, vq[i].req, vq[i].addr, vq[i].ir,
                  vq[i].v, vq[i].f, vq[i].cnt);
        end

        // Reset clears the sticky fault without a clock edge.
        rst = 1'b1;
        #1;
        check("err_async_reset", 0, 0, 32'h0, 32'h0, 0, 0, 16'd0);

        // Memory never answers: request lives exactly TIMEOUT cycles.
        drive(32'h20, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        reqcyc = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.MEM_REQ) reqcyc++;
        end
        total++;
        if (reqcyc != 4) begin
            bad++;
            $display("FAIL timeout_req_cycles: got %0d want 4", reqcyc);
        end
        check("timeout_err", 0, 0, 32'h20, 32'h0, 0, 1, 16'd0);
        drive(32'h20, 1, 32'h1234_5678, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("late_ack_ignored", 0, 0, 32'h20, 32'h0, 0, 1, 16'd0);

        // Reset mid-WAIT abandons the request immediately.
        rst = 1'b1;
        drive(32'h24, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("wait_entry", 0, 1, 32'h24, 32'h0, 0, 0, 16'd0);
        #3;
        rst = 1'b1;
        #1;
        check("async_mid_wait", 0, 0, 32'h0, 32'h0, 0, 0, 16'd0);
        drive(32'h24, 1, 32'hCAFE_F00D, 0, 0);
        @(posedge clk);
        #1;
        check("ack_during_reset", 0, 0, 32'h0, 32'h0, 0, 0, 16'd0);
        drive(32'h24, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("restart_request", 0, 1, 32'h24, 32'h0, 0, 0, 16'd0);
        drive(32'h24, 1, 32'h0BAD_F00D, 0, 0);
        @(posedge clk);
        #1;
        check("restart_hold", 0, 0, 32'h24, 32'h0BAD_F00D, 1, 0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
